strobe_scan: RTL and testbench

Column-scan scheduler for the LED strobe datapath. It shares one `led` drive line between `COLS` multiplexed columns. Each column gets a fixed time slot, and `led` is pulse-width-modulated per column from a 4-bit brightness level. A blanking gap between slots prevents ghosting. The block sits between the debounced user inputs / host write port and the physical column and LED pins.

---
 rtl/strobe_scan_if.sv | 26 ++
 rtl/strobe_scan.sv | 129 ++++++++++++
 tb/tb_strobe_scan.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/strobe_scan_if.sv
// Bundle of the scan control, brightness write port and column/LED drive
// signals exchanged between the host side and the strobe scanner.
interface strobe_scan_if #(
    parameter int COLS = 4
);
    localparam int AW = $clog2(COLS);

    logic            enable;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [3:0]      wr_data;
    logic [COLS-1:0] col;
    logic            led;
    logic [AW-1:0]   active_col;
    logic            frame_done;

    modport master (
        output enable, wr_en, wr_addr, wr_data,
        input  col, led, active_col, frame_done
    );

    modport slave (
        input  enable, wr_en, wr_addr, wr_data,
        output col, led, active_col, frame_done
    );
endinterface

// File: rtl/strobe_scan.sv
// Column-scan scheduler: time-multiplexes one PWM LED line across COLS columns,
// with a blanking gap before every column slot to suppress ghosting.
module strobe_scan #(
    parameter int COLS   = 4,
    parameter int BLANK  = 2,
    parameter int REPEAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    strobe_scan_if.slave bus
);
    localparam int AW = $clog2(COLS);
    localparam int BW = (BLANK > 1) ? $clog2(BLANK) : 1;
    localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_ON
    } state_t;

    state_t          state, state_n;
    logic [BW-1:0]   bcnt, bcnt_n;
    logic [3:0]      p, p_n;
    logic [RW-1:0]   rcnt, rcnt_n;
    logic [3:0]      shadow, shadow_n;
    logic [COLS-1:0] col_q, col_n;
    logic            led_q, led_n;
    logic [AW-1:0]   act_q, act_n;
    logic            fd_q, fd_n;
    logic [3:0]      level [COLS];
    logic            on_last;

    function automatic logic [COLS-1:0] onehot(input logic [AW-1:0] idx);
        logic [COLS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Brightness registers: host writes land in any state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < COLS; i++) level[i] <= 4'd0;
        end else if (bus.wr_en) begin
            level[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= S_IDLE;
            bcnt   <= '0;
            p      <= 4'd0;
            rcnt   <= '0;
            shadow <= 4'd0;
            col_q  <= '0;
            led_q  <= 1'b0;
            act_q  <= '0;
            fd_q   <= 1'b0;
        end else begin
            state  <= state_n;
            bcnt   <= bcnt_n;
            p      <= p_n;
            rcnt   <= rcnt_n;
            shadow <= shadow_n;
            col_q  <= col_n;
            led_q  <= led_n;
            act_q  <= act_n;
            fd_q   <= fd_n;
        end
    end

    assign on_last = (p == 4'd15) && (rcnt == RW'(REPEAT - 1));

    // Outputs are computed for the cycle after the edge, so every pin is a flop.
    always_comb begin
        state_n  = state;
        bcnt_n   = bcnt;
        p_n      = p;
        rcnt_n   = rcnt;
        shadow_n = shadow;
        col_n    = '0;
        led_n    = 1'b0;
        act_n    = act_q;
        fd_n     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.enable) begin
                    state_n = S_BLANK;
                    bcnt_n  = '0;
                    act_n   = '0;
                end
            end
            S_BLANK: begin
                if (bcnt == BW'(BLANK - 1)) begin
                    // Latch brightness at slot entry; a same-edge write is not seen.
                    state_n  = S_ON;
                    p_n      = 4'd0;
                    rcnt_n   = '0;
                    shadow_n = level[act_q];
                    col_n    = onehot(act_q);
                    led_n    = (level[act_q] != 4'd0);
                end else begin
                    bcnt_n = bcnt + BW'(1);
                end
            end
            S_ON: begin
                if (on_last) begin
                    act_n   = act_q + AW'(1);
                    fd_n    = (act_q == AW'(COLS - 1));
                    bcnt_n  = '0;
                    state_n = bus.enable ? S_BLANK : S_IDLE;
                end else begin
                    p_n = p + 4'd1;
                    if (p == 4'd15) rcnt_n = rcnt + RW'(1);
                    col_n = onehot(act_q);
                    led_n = (p_n < shadow);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.col        = col_q;
    assign bus.led        = led_q;
    assign bus.active_col = act_q;
    assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_strobe_scan.sv
// Directed bench for strobe_scan: default 4-column build plus a 2-column,
// 1-blank, 2-repeat build, checked slot by slot against hand-derived patterns.
module tb_strobe_scan;
    localparam int BL4 = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    strobe_scan_if #(.COLS(4)) b4 ();
    strobe_scan_if #(.COLS(2)) b2 ();

    strobe_scan #(.COLS(4), .BLANK(2), .REPEAT(1)) dut4 (
        .clk  (clk),
        .reset(reset),
        .bus  (b4)
    );

    strobe_scan #(.COLS(2), .BLANK(1), .REPEAT(2)) dut2 (
        .clk  (clk),
        .reset(reset),
        .bus  (b2)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int sel = 0;
    int slotno = 0;
    int wt[8], wa[8], wd[8];
    int wn = 0;
    int wi = 0;
    int en_off_at = -1;
    int rst_at = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sched(input int a, input int d, input int dly);
        wt[wn] = cyc + dly;
        wa[wn] = a;
        wd[wn] = d;
        wn++;
    endtask

    // One clock: apply any due write/enable-drop/reset, then move past the edge.
    task automatic step();
        if (wi < wn && wt[wi] <= cyc) begin
            if (sel == 0) begin
                b4.wr_en = 1'b1; b4.wr_addr = 2'(wa[wi]); b4.wr_data = 4'(wd[wi]);
            end else begin
                b2.wr_en = 1'b1; b2.wr_addr = 1'(wa[wi]); b2.wr_data = 4'(wd[wi]);
            end
            wi++;
        end
        if (cyc == en_off_at) begin
            if (sel == 0) b4.enable = 1'b0;
            else          b2.enable = 1'b0;
        end
        if (cyc == rst_at) reset = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        b4.wr_en = 1'b0;
        b2.wr_en = 1'b0;
        reset    = 1'b1;
    endtask

    task automatic sample(output logic [31:0] c, output logic [31:0] l,
                          output logic [31:0] a, output logic [31:0] f);
        if (sel == 0) begin
            c = 32'(b4.col); l = 32'(b4.led); a = 32'(b4.active_col); f = 32'(b4.frame_done);
        end else begin
            c = 32'(b2.col); l = 32'(b2.led); a = 32'(b2.active_col); f = 32'(b2.frame_done);
        end
    endtask

    // Entered at the first blank cycle of a slot; leaves at the next slot's first blank cycle.
    task automatic slot(input int c, input int lvl, input int fd_exp);
        logic [31:0] cv, lv, av, fv;
        int nb, nr, badcol, badact, badled, hi, fdx;
        logic [31:0] fd0;
        nb = (sel == 0) ? BL4 : 1;
        nr = (sel == 0) ? 1 : 2;
        badcol = 0; badact = 0; badled = 0; hi = 0; fdx = 0; fd0 = '0;
        for (int b = 0; b < nb; b++) begin
            sample(cv, lv, av, fv);
            if (b == 0) fd0 = fv;
            else        fdx += int'(fv);
            if (cv != 0) badcol++;
            if (av != 32'(c)) badact++;
            if (lv != 0) badled++;
            step();
        end
        for (int i = 0; i < 16 * nr; i++) begin
            sample(cv, lv, av, fv);
            if (cv != (32'd1 << c)) badcol++;
            if (av != 32'(c)) badact++;
            if (lv != 32'(((i % 16) < lvl) ? 1 : 0)) badled++;
            hi  += int'(lv);
            fdx += int'(fv);
            step();
        end
        chk($sformatf("s%0d_col", slotno), 32'(badcol), 0);
        chk($sformatf("s%0d_act", slotno), 32'(badact), 0);
        chk($sformatf("s%0d_ledpos", slotno), 32'(badled), 0);
        chk($sformatf("s%0d_ledcnt", slotno), 32'(hi), 32'(lvl * nr));
        chk($sformatf("s%0d_fd", slotno), fd0, 32'(fd_exp));
        chk($sformatf("s%0d_fdx", slotno), 32'(fdx), 0);
        slotno++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cv, lv, av, fv;
        int cnt;
        reset = 1'b0;
        b4.enable = 1'b0; b4.wr_en = 1'b0; b4.wr_addr = '0; b4.wr_data = '0;
        b2.enable = 1'b0; b2.wr_en = 1'b0; b2.wr_addr = '0; b2.wr_data = '0;
        rst_at = 0;
        step();
        sample(cv, lv, av, fv);
        chk("rst_col", cv, 0);
        chk("rst_led", lv, 0);
        chk("rst_act", av, 0);
        chk("rst_fd", fv, 0);

        // All levels zero: dark scan across the columns.
        b4.enable = 1'b1;
        step();
        slot(0, 0, 0); slot(1, 0, 0); slot(2, 0, 0); slot(3, 0, 0);

        sched(1, 4, 0); sched(2, 15, 1); sched(3, 8, 2);
        slot(0, 0, 1); slot(1, 4, 0); slot(2, 15, 0); slot(3, 8, 0);

        // Mid-slot write to the active column only shows on its next slot.
        sched(1, 12, 0);
        slot(0, 0, 1);
        sched(1, 0, BL4 + 5);
        slot(1, 12, 0); slot(2, 15, 0); slot(3, 8, 0);
        slot(0, 0, 1); slot(1, 0, 0);

        en_off_at = cyc + 5;
        slot(2, 15, 0);
        sample(cv, lv, av, fv);
        chk("idle_col", cv, 0);
        chk("idle_led", lv, 0);
        chk("idle_act", av, 3);
        chk("idle_fd", fv, 0);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            sample(cv, lv, av, fv);
            if (cv != 0 || fv != 0 || lv != 0) cnt++;
        end
        chk("idle_hold", 32'(cnt), 0);

        b4.enable = 1'b1;
        step();
        slot(0, 0, 0); slot(1, 0, 0); slot(2, 15, 0);

        // Reset pulse in the middle of column 3's ON window.
        rst_at = cyc + BL4 + 5;
        for (int i = 0; i < BL4 + 5; i++) step();
        sample(cv, lv, av, fv);
        chk("prerst_col", cv, 8);
        step();
        sample(cv, lv, av, fv);
        chk("rstm_col", cv, 0);
        chk("rstm_led", lv, 0);
        chk("rstm_act", av, 0);
        chk("rstm_fd", fv, 0);
        step();
        slot(0, 0, 0); slot(1, 0, 0); slot(2, 0, 0); slot(3, 0, 0);

        // Two-column build: 33-cycle slots, level 1 lights twice per slot.
        sel = 1;
        sched(0, 1, 0);
        step();
        b2.enable = 1'b1;
        step();
        slot(0, 1, 0); slot(1, 0, 0); slot(0, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
